// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and fetch state encoding for the IF stage
package fetch_stage_pkg;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      F_FETCH    = 2'd0,
      F_HELD     = 2'd1,
      F_REDIRECT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// rtl/fetch_stage_ifid_reg.sv - IF/ID pipeline register with hold and flush
module fetch_stage_ifid_reg
   import fetch_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              hold,
   input  logic              flush,
   input  logic              load,
   input  logic [DATA_W-1:0] instr,
   input  logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] IFID_instr,
   output logic [ADDR_W-1:0] IFID_PC,
   output logic              IFID_valid
);

   // Flush outranks hold; a non-loading, non-held cycle writes a bubble but keeps the PC.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         IFID_instr <= DATA_W'(NOP);
         IFID_PC    <= '0;
         IFID_valid <= 1'b0;
      end else if (flush) begin
         IFID_instr <= DATA_W'(NOP);
         IFID_PC    <= '0;
         IFID_valid <= 1'b0;
      end else if (!hold) begin
         if (load) begin
            IFID_instr <= instr;
            IFID_PC    <= pc;
            IFID_valid <= 1'b1;
         end else begin
            IFID_instr <= DATA_W'(NOP);
            IFID_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, imem handshake, skid buffer, IF/ID register
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic              clock,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              imem_ready,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_bubbles,
`endif
   output logic [DATA_W-1:0] IFID_instr,
   output logic [ADDR_W-1:0] IFID_PC,
   output logic              IFID_valid
);

   fetch_state_e      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] skid;
   logic              done;
   logic              load;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] next_addr;
   logic [DATA_W-1:0] load_instr;

   assign imem_req   = (state == F_FETCH || state == F_REDIRECT) && !reset;
   assign imem_addr  = req_addr;
   assign done       = imem_req && imem_ready;
   assign target     = branch_target & ~ADDR_W'(3);
   assign next_addr  = req_addr + ADDR_W'(4);
   assign load       = (state == F_FETCH && done) || state == F_HELD;
   assign load_instr = (state == F_HELD) ? skid : imem_rdata;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= F_FETCH;
         pc       <= PC_RESET;
         req_addr <= PC_RESET;
         skid     <= DATA_W'(NOP);
      end else if (branch_taken) begin
         pc   <= target;
         skid <= DATA_W'(NOP);
         // An outstanding request must complete before the new address can be issued.
         if (state != F_HELD && !imem_ready) begin
            state <= F_REDIRECT;
         end else begin
            req_addr <= target;
            state    <= F_FETCH;
         end
      end else begin
         case (state)
            F_FETCH: begin
               if (done) begin
                  if (stall) begin
                     skid  <= imem_rdata;
                     state <= F_HELD;
                  end else begin
                     pc       <= next_addr;
                     req_addr <= next_addr;
                  end
               end
            end
            F_HELD: begin
               if (!stall) begin
                  pc       <= next_addr;
                  req_addr <= next_addr;
                  state    <= F_FETCH;
               end
            end
            F_REDIRECT: begin
               if (done) begin
                  req_addr <= pc;
                  state    <= F_FETCH;
               end
            end
            default: state <= F_FETCH;
         endcase
      end
   end

   fetch_stage_ifid_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ifid_reg (
      .clock      (clock),
      .reset      (reset),
      .hold       (stall),
      .flush      (branch_taken),
      .load       (load),
      .instr      (load_instr),
      .pc         (next_addr),
      .IFID_instr (IFID_instr),
      .IFID_PC    (IFID_PC),
      .IFID_valid (IFID_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_bubbles <= '0;
      end else if (!stall) begin
         if (!branch_taken && load) perf_fetched <= perf_fetched + 32'd1;
         else                       perf_bubbles <= perf_bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req, imem_ready = 1'b1, stall = 1'b0, branch_taken = 1'b0;
   logic [31:0] imem_addr, imem_rdata, branch_target = '0;
   logic [31:0] IFID_instr, IFID_PC;
   logic        IFID_valid;

   logic        imem_req1, IFID_valid1;
   logic [31:0] imem_addr1, imem_rdata1, IFID_instr1, IFID_PC1;
   logic        ready1 = 1'b1, stall1 = 1'b0, branch1 = 1'b0;
   logic [31:0] target1 = '0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_bubbles, perf_fetched1, perf_bubbles1;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   assign imem_rdata  = imem_addr ^ 32'hDEAD_0000;
   assign imem_rdata1 = imem_addr1 ^ 32'hDEAD_0000;

   fetch_stage #(.ADDR_W(32), .DATA_W(32), .PC_RESET(32'h0000_0000)) dut0 (
      .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
`endif
      .IFID_instr(IFID_instr), .IFID_PC(IFID_PC), .IFID_valid(IFID_valid)
   );

   fetch_stage #(.ADDR_W(32), .DATA_W(32), .PC_RESET(32'hFFFF_FFF8)) dut1 (
      .clock(clock), .reset(reset), .imem_req(imem_req1), .imem_addr(imem_addr1),
      .imem_rdata(imem_rdata1), .imem_ready(ready1), .stall(stall1),
      .branch_taken(branch1), .branch_target(target1),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetched(perf_fetched1), .perf_bubbles(perf_bubbles1),
`endif
      .IFID_instr(IFID_instr1), .IFID_PC(IFID_PC1), .IFID_valid(IFID_valid1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                             input logic v);
      check({tag, "_instr"}, IFID_instr, ins);
      check({tag, "_pc"}, IFID_PC, pc);
      check({tag, "_valid"}, {31'd0, IFID_valid}, {31'd0, v});
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      tick;
      tick;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check_ifid("rst", 32'h0, 32'h0, 1'b0);
      check("rst_addr1", imem_addr1, 32'hFFFF_FFF8);

      // Zero-wait streaming, plus the wrapping instance alongside
      reset = 1'b0;
      tick;
      check_ifid("t1a", 32'hDEAD_0000, 32'h4, 1'b1);
      check("t5a_pc", IFID_PC1, 32'hFFFF_FFFC);
      check("t5a_instr", IFID_instr1, 32'h2152_FFF8);
      tick;
      check_ifid("t1b", 32'hDEAD_0004, 32'h8, 1'b1);
      check("t5b_pc", IFID_PC1, 32'h0000_0000);
      check("t5b_instr", IFID_instr1, 32'h2152_FFFC);
      tick;
      check_ifid("t1c", 32'hDEAD_0008, 32'hC, 1'b1);
      check("t5c_pc", IFID_PC1, 32'h0000_0004);
      check("t5c_instr", IFID_instr1, 32'hDEAD_0000);

      // Three wait cycles on the fetch at 0xC
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         check("t2_wait_valid", {31'd0, IFID_valid}, 32'd0);
         check("t2_wait_addr", imem_addr, 32'hC);
         check("t2_wait_req", {31'd0, imem_req}, 32'd1);
      end
      imem_ready = 1'b1;
      tick;
      check_ifid("t2_done", 32'hDEAD_000C, 32'h10, 1'b1);
      check("t2_next_addr", imem_addr, 32'h10);
      imem_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      check("t2_perf_fetched", perf_fetched, 32'd4);
      check("t2_perf_bubbles", perf_bubbles, 32'd3);
`endif

      // Stall held for four cycles while the fetch at 0x10 completes
      stall = 1'b1;
      imem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("t3_state", 32'(dut0.state), 32'(F_HELD));
         check("t3_req", {31'd0, imem_req}, 32'd0);
         check_ifid("t3_frozen", 32'hDEAD_000C, 32'h10, 1'b1);
      end
      stall = 1'b0;
      tick;
      check_ifid("t3_skid", 32'hDEAD_0010, 32'h14, 1'b1);
      tick;
      check_ifid("t3_after", 32'hDEAD_0014, 32'h18, 1'b1);

      // Branch while the fetch at 0x18 waits
      imem_ready = 1'b0;
      tick;
      check("t4_bubble_valid", {31'd0, IFID_valid}, 32'd0);
      branch_taken = 1'b1;
      branch_target = 32'h0000_0043;
      tick;
      branch_taken = 1'b0;
      check_ifid("t4_flush", 32'h0, 32'h0, 1'b0);
      check("t4_state", 32'(dut0.state), 32'(F_REDIRECT));
      check("t4_old_addr", imem_addr, 32'h18);
      tick;
      check("t4_still_addr", imem_addr, 32'h18);
      check("t4_still_req", {31'd0, imem_req}, 32'd1);
      imem_ready = 1'b1;
      tick;
      check("t4_dropped_valid", {31'd0, IFID_valid}, 32'd0);
      check("t4_new_addr", imem_addr, 32'h40);
      tick;
      check_ifid("t4_target", 32'hDEAD_0040, 32'h44, 1'b1);

      // Flush wins over stall; done data at 0x44 is discarded
      stall = 1'b1;
      branch_taken = 1'b1;
      branch_target = 32'h0000_0100;
      tick;
      stall = 1'b0;
      branch_taken = 1'b0;
      check_ifid("sf_flush", 32'h0, 32'h0, 1'b0);
      check("sf_addr", imem_addr, 32'h100);
      tick;
      check_ifid("sf_fetch", 32'hDEAD_0100, 32'h104, 1'b1);

      // Asynchronous reset in the middle of a wait
      imem_ready = 1'b0;
      tick;
`ifdef FETCH_PERF_CNT_EN
      check("t6_perf_fetched", perf_fetched, 32'd8);
      check("t6_perf_bubbles", perf_bubbles, 32'd8);
`endif
      reset = 1'b1;
      #1;
      check("t6_req", {31'd0, imem_req}, 32'd0);
      check("t6_addr", imem_addr, 32'h0);
      check_ifid("t6", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
      check("t6_perf_fetched_rst", perf_fetched, 32'd0);
      check("t6_perf_bubbles_rst", perf_bubbles, 32'd0);
`endif
      tick;
      reset = 1'b0;
      imem_ready = 1'b1;
      tick;
      check_ifid("t6_restart", 32'hDEAD_0000, 32'h4, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
